// File: rtl/mfp_adc_max10_responder_if.sv
// mfp_adc_max10_responder_if: MAX10 ADC command/response streams plus the sticky error flag.
interface mfp_adc_max10_responder_if;
    logic        ADC_C_Valid;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_C_SOP;
    logic        ADC_C_EOP;
    logic        ADC_C_Ready;
    logic        ADC_R_Valid;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;
    logic        ADC_R_SOP;
    logic        ADC_R_EOP;
    logic        ADC_Err;
    logic        ADC_Err_Clear;

    modport master (
        output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP, ADC_Err_Clear,
        input  ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP, ADC_Err
    );

    modport slave (
        input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP, ADC_Err_Clear,
        output ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP, ADC_Err
    );
endinterface

// File: rtl/mfp_adc_max10_responder.sv
// mfp_adc_max10_responder: MAX10 ADC sequencer stand-in with a fixed conversion time,
// one-deep command buffer, deterministic results and protocol-error flagging.
module mfp_adc_max10_responder #(
    parameter int CONV_CYCLES = 4
) (
    input logic CLK,
    input logic RESET,
    mfp_adc_max10_responder_if.slave adc
);
    localparam logic [7:0] CNT_INIT = 8'(CONV_CYCLES - 1);

    logic       eng_busy, eng_sop, eng_eop;
    logic [7:0] eng_cnt;
    logic [4:0] eng_ch;
    logic       hold_full, hold_sop, hold_eop;
    logic [4:0] hold_ch;
    logic [6:0] seq;
    logic       in_packet;
    logic       fin, acc, to_eng, to_hold, legal_c, legal_e, bad, hold_full_n;

    always_comb begin
        fin = eng_busy && eng_cnt == 8'd0;
        acc = adc.ADC_C_Valid && adc.ADC_C_Ready;
        to_eng = acc && (!eng_busy || (fin && !hold_full));
        to_hold = acc && !to_eng;
        legal_c = adc.ADC_C_Channel <= 5'd8 || adc.ADC_C_Channel == 5'd17;
        legal_e = eng_ch <= 5'd8 || eng_ch == 5'd17;
        // SOP must equal "not in a packet"; SOP == in_packet is the violation
        bad = acc && (adc.ADC_C_SOP == in_packet || !legal_c);
        hold_full_n = to_hold || (hold_full && !fin);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            eng_busy <= 1'b0;
            eng_cnt <= 8'd0;
            eng_ch <= 5'd0;
            eng_sop <= 1'b0;
            eng_eop <= 1'b0;
            hold_full <= 1'b0;
            hold_ch <= 5'd0;
            hold_sop <= 1'b0;
            hold_eop <= 1'b0;
            seq <= 7'd0;
            in_packet <= 1'b0;
            adc.ADC_C_Ready <= 1'b0;
            adc.ADC_R_Valid <= 1'b0;
            adc.ADC_R_Channel <= 5'd0;
            adc.ADC_R_Data <= 12'd0;
            adc.ADC_R_SOP <= 1'b0;
            adc.ADC_R_EOP <= 1'b0;
            adc.ADC_Err <= 1'b0;
        end else begin
            if (fin && hold_full) begin
                eng_ch <= hold_ch;
                eng_sop <= hold_sop;
                eng_eop <= hold_eop;
                eng_cnt <= CNT_INIT;
            end else if (to_eng) begin
                eng_busy <= 1'b1;
                eng_ch <= adc.ADC_C_Channel;
                eng_sop <= adc.ADC_C_SOP;
                eng_eop <= adc.ADC_C_EOP;
                eng_cnt <= CNT_INIT;
            end else if (fin) begin
                eng_busy <= 1'b0;
            end else if (eng_busy) begin
                eng_cnt <= eng_cnt - 8'd1;
            end
            if (to_hold) begin
                hold_ch <= adc.ADC_C_Channel;
                hold_sop <= adc.ADC_C_SOP;
                hold_eop <= adc.ADC_C_EOP;
            end
            hold_full <= hold_full_n;
            adc.ADC_C_Ready <= !hold_full_n;
            adc.ADC_R_Valid <= fin;
            adc.ADC_R_Channel <= fin ? eng_ch : 5'd0;
            adc.ADC_R_Data <= (fin && legal_e) ? {eng_ch, seq} : 12'd0;
            adc.ADC_R_SOP <= fin && eng_sop;
            adc.ADC_R_EOP <= fin && eng_eop;
            if (fin)
                seq <= seq + 7'd1;
            if (acc && adc.ADC_C_EOP)
                in_packet <= 1'b0;
            else if (acc && adc.ADC_C_SOP)
                in_packet <= 1'b1;
            adc.ADC_Err <= bad || (adc.ADC_Err && !adc.ADC_Err_Clear);
        end
    end
endmodule

// File: tb/tb_mfp_adc_max10_responder.sv
// tb_mfp_adc_max10_responder: randomized scoreboard bench; the model predicts each result's
// content and completion edge from arrival order and conversion time.
module tb_mfp_adc_max10_responder;
    localparam int CONV = 4;

    typedef struct {
        logic [4:0]  ch;
        logic [11:0] data;
        logic        sop;
        logic        eop;
        int          fin;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    mfp_adc_max10_responder_if bus ();

    mfp_adc_max10_responder #(.CONV_CYCLES(CONV)) dut (.CLK(CLK), .RESET(RESET), .adc(bus.slave));

    always #5 CLK = ~CLK;

    exp_t q[$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int f_prev = 0;
    int last_start = 0;
    logic [6:0] seqm = 7'd0;
    logic in_pkt = 1'b0;
    logic errm = 1'b0;
    logic ready_exp = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference model: each command starts when both it has arrived and the previous one is done.
    task automatic model_step();
        logic legal, e;
        int start;
        exp_t x;
        cyc++;
        if (RESET) begin
            q.delete();
            seqm = 7'd0;
            in_pkt = 1'b0;
            errm = 1'b0;
            f_prev = 0;
            last_start = 0;
            ready_exp = 1'b0;
        end else begin
            e = 1'b0;
            if (bus.ADC_C_Valid && bus.ADC_C_Ready) begin
                legal = bus.ADC_C_Channel <= 8 || bus.ADC_C_Channel == 17;
                e = !legal || (bus.ADC_C_SOP && in_pkt) || (!bus.ADC_C_SOP && !in_pkt);
                start = (cyc > f_prev) ? cyc : f_prev;
                f_prev = start + CONV;
                last_start = start;
                x.ch = bus.ADC_C_Channel;
                x.data = legal ? {bus.ADC_C_Channel, seqm} : 12'h000;
                x.sop = bus.ADC_C_SOP;
                x.eop = bus.ADC_C_EOP;
                x.fin = f_prev;
                q.push_back(x);
                seqm = seqm + 7'd1;
                if (bus.ADC_C_EOP) in_pkt = 1'b0;
                else if (bus.ADC_C_SOP) in_pkt = 1'b1;
            end
            errm = e ? 1'b1 : (bus.ADC_Err_Clear ? 1'b0 : errm);
            ready_exp = last_start <= cyc;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        exp_t x;
        @(negedge CLK);
        if (cyc > 0) begin
            check("c_ready", bus.ADC_C_Ready, ready_exp);
            check("err", bus.ADC_Err, errm);
            if (bus.ADC_R_Valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    x = q.pop_front();
                    check("r_cycle", cyc, x.fin);
                    check("r_channel", bus.ADC_R_Channel, x.ch);
                    check("r_data", bus.ADC_R_Data, x.data);
                    check("r_sop", bus.ADC_R_SOP, x.sop);
                    check("r_eop", bus.ADC_R_EOP, x.eop);
                end
            end else begin
                check("r_idle_fields", {bus.ADC_R_Channel, bus.ADC_R_Data, bus.ADC_R_SOP, bus.ADC_R_EOP}, 0);
                if (q.size() > 0 && q[0].fin < cyc) begin
                    x = q.pop_front();
                    check("missing_result", cyc, x.fin);
                end
            end
        end
    end

    task automatic send(input logic [4:0] ch, input logic sop, input logic eop, input logic clr);
        logic got;
        got = 1'b0;
        bus.ADC_C_Valid = 1'b1;
        bus.ADC_C_Channel = ch;
        bus.ADC_C_SOP = sop;
        bus.ADC_C_EOP = eop;
        bus.ADC_Err_Clear = clr;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge CLK);
            got = bus.ADC_C_Ready;
            @(negedge CLK);
        end
        if (!got) check("accept_timeout", 0, 1);
        bus.ADC_C_Valid = 1'b0;
        bus.ADC_Err_Clear = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.ADC_C_Valid = 1'b0;
        bus.ADC_Err_Clear = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_pulse();
        bus.ADC_Err_Clear = 1'b1;
        @(negedge CLK);
        bus.ADC_Err_Clear = 1'b0;
    endtask

    initial begin
        bus.ADC_C_Valid = 1'b0;
        bus.ADC_C_Channel = 5'd0;
        bus.ADC_C_SOP = 1'b0;
        bus.ADC_C_EOP = 1'b0;
        bus.ADC_Err_Clear = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        idle(2);
        send(5'd3, 1'b1, 1'b1, 1'b0);
        idle(10);
        send(5'd0, 1'b1, 1'b0, 1'b0);
        send(5'd1, 1'b0, 1'b0, 1'b0);
        send(5'd2, 1'b0, 1'b0, 1'b0);
        send(5'd17, 1'b0, 1'b1, 1'b0);
        idle(20);
        send(5'd4, 1'b1, 1'b0, 1'b0);
        send(5'd5, 1'b1, 1'b0, 1'b0);
        send(5'd6, 1'b0, 1'b1, 1'b0);
        idle(12);
        clear_pulse();
        send(5'd12, 1'b1, 1'b1, 1'b0);
        idle(12);
        send(5'd7, 1'b0, 1'b1, 1'b1);
        idle(12);
        clear_pulse();
        for (int i = 0; i < 129; i++)
            send(5'($urandom_range(0, 8)), 1'b1, 1'b1, 1'b0);
        idle(12);
        for (int i = 0; i < 300; i++) begin
            send(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 9));
        end
        idle(12);
        send(5'd1, 1'b1, 1'b0, 1'b0);
        send(5'd2, 1'b0, 1'b1, 1'b0);
        idle(1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        idle(15);
        send(5'd8, 1'b1, 1'b1, 1'b0);
        idle(12);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
